// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage for the five-stage RISC-V pipeline.
// Owns the PC, drives the imem handshake and loads IF/ID.
module instruction_fetch_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_E,
  input  logic        IF_ID_E,
  input  logic        redirect,
  input  logic [31:0] TA,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] IF_ID_instr,
  output logic [31:0] IF_ID_PC,
  output logic        IF_ID_valid
);

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DRAIN
  } state_t;

  state_t      state;
  state_t      state_d;
  logic [31:0] pc;
  logic [31:0] pc_d;
  logic [31:0] pend;
  logic [31:0] pend_d;
  logic [31:0] buf_instr;
  logic [31:0] buf_instr_d;
  logic [31:0] buf_pc;
  logic [31:0] buf_pc_d;
  logic        buf_valid;
  logic        buf_valid_d;
  logic [31:0] instr_d;
  logic [31:0] ifpc_d;
  logic        valid_d;
  logic        advance;
  logic        accept;
  logic [31:0] target;
  logic [31:0] pc_inc;

  assign advance = PC_E & IF_ID_E;
  assign target  = TA & ~32'h3;
  assign pc_inc  = pc + 32'd4;

  // No request while holding a word or while reset is asserted
  assign imem_req  = !reset && (state != HOLD);
  // DRAIN keeps the abandoned address stable until memory takes it
  assign imem_addr = (state == DRAIN) ? pend : pc;
  assign accept    = imem_req & imem_ready;

  // Next-state and next-register logic; redirect wins over stalls
  always_comb begin
    state_d     = state;
    pc_d        = pc;
    pend_d      = pend;
    buf_instr_d = buf_instr;
    buf_pc_d    = buf_pc;
    buf_valid_d = buf_valid;
    instr_d     = IF_ID_instr;
    ifpc_d      = IF_ID_PC;
    valid_d     = IF_ID_valid;
    unique case (state)
      FETCH: begin
        if (redirect) begin
          pc_d        = target;
          instr_d     = NOP_INSTR;
          valid_d     = 1'b0;
          buf_valid_d = 1'b0;
          if (!imem_ready) begin
            pend_d  = pc;
            state_d = DRAIN;
          end
        end else if (accept && advance) begin
          instr_d = imem_rdata;
          ifpc_d  = pc;
          valid_d = 1'b1;
          pc_d    = pc_inc;
        end else if (accept) begin
          buf_instr_d = imem_rdata;
          buf_pc_d    = pc;
          buf_valid_d = 1'b1;
          state_d     = HOLD;
        end else if (advance) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d        = target;
          instr_d     = NOP_INSTR;
          valid_d     = 1'b0;
          buf_valid_d = 1'b0;
          state_d     = FETCH;
        end else if (advance) begin
          instr_d     = buf_instr;
          ifpc_d      = buf_pc;
          valid_d     = buf_valid;
          buf_valid_d = 1'b0;
          pc_d        = pc_inc;
          state_d     = FETCH;
        end
      end
      DRAIN: begin
        if (redirect) begin
          pc_d        = target;
          instr_d     = NOP_INSTR;
          valid_d     = 1'b0;
          buf_valid_d = 1'b0;
        end
        if (accept) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State and pipeline register update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      pend        <= RESET_PC;
      buf_instr   <= NOP_INSTR;
      buf_pc      <= 32'h0;
      buf_valid   <= 1'b0;
      IF_ID_instr <= NOP_INSTR;
      IF_ID_PC    <= 32'h0;
      IF_ID_valid <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      pend        <= pend_d;
      buf_instr   <= buf_instr_d;
      buf_pc      <= buf_pc_d;
      buf_valid   <= buf_valid_d;
      IF_ID_instr <= instr_d;
      IF_ID_PC    <= ifpc_d;
      IF_ID_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage.
// Expected IF/ID entries travel through a scoreboard queue.
module tb_instruction_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        PC_E;
  logic        IF_ID_E;
  logic        redirect;
  logic [31:0] TA;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] IF_ID_instr;
  logic [31:0] IF_ID_PC;
  logic        IF_ID_valid;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  assign imem_rdata = imem_ready ? memw(imem_addr) : 32'hDEAD_BEEF;

  always #5 clk = ~clk;

  instruction_fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .PC_E       (PC_E),
    .IF_ID_E    (IF_ID_E),
    .redirect   (redirect),
    .TA         (TA),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .IF_ID_instr(IF_ID_instr),
    .IF_ID_PC   (IF_ID_PC),
    .IF_ID_valid(IF_ID_valid)
  );

  task automatic drive(input logic pe, input logic ie,
                       input logic rdy, input logic red,
                       input logic [31:0] ta);
    PC_E       = pe;
    IF_ID_E    = ie;
    imem_ready = rdy;
    redirect   = red;
    TA         = ta;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_req got %b want 0", imem_req);
    end
    tick();
    checks++;
    if (IF_ID_valid !== 1'b0 || IF_ID_instr !== NOP ||
        IF_ID_PC !== 32'h0) begin
      errors++;
      $display("FAIL rst_ifid got v=%b i=%h pc=%h want v=0 i=%h pc=0",
               IF_ID_valid, IF_ID_instr, IF_ID_PC, NOP);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rst_first got req=%b addr=%h want req=1 addr=0",
               imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential;
    logic [31:0] a;
    logic [31:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a = i * 4;
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== a) begin
        errors++;
        $display("FAIL seq_addr got req=%b addr=%h want req=1 addr=%h",
                 imem_req, imem_addr, a);
      end
      exp_q.push_back(a);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (IF_ID_valid !== 1'b1 || IF_ID_PC !== e ||
          IF_ID_instr !== memw(e)) begin
        errors++;
        $display("FAIL seq_ifid got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                 IF_ID_valid, IF_ID_PC, IF_ID_instr, e, memw(e));
      end
    end
  endtask

  task automatic test_load_use;
    logic [31:0] e;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      exp_q.push_back(32'(i * 4));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (IF_ID_valid !== 1'b1 || IF_ID_PC !== e) begin
        errors++;
        $display("FAIL lu_pre got v=%b pc=%h want v=1 pc=%h",
                 IF_ID_valid, IF_ID_PC, e);
      end
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      errors++;
      $display("FAIL lu_addr8 got req=%b addr=%h want req=1 addr=8",
               imem_req, imem_addr);
    end
    exp_q.push_back(32'h8);
    tick();
    checks++;
    if (IF_ID_valid !== 1'b1 || IF_ID_PC !== 32'h4 ||
        IF_ID_instr !== memw(32'h4)) begin
      errors++;
      $display("FAIL lu_hold got v=%b pc=%h want v=1 pc=4",
               IF_ID_valid, IF_ID_PC);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL lu_holdreq got req=%b want 0", imem_req);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (IF_ID_valid !== 1'b1 || IF_ID_PC !== e ||
        IF_ID_instr !== memw(e)) begin
      errors++;
      $display("FAIL lu_release got v=%b pc=%h i=%h want pc=%h i=%h",
               IF_ID_valid, IF_ID_PC, IF_ID_instr, e, memw(e));
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
      errors++;
      $display("FAIL lu_next got req=%b addr=%h want req=1 addr=c",
               imem_req, imem_addr);
    end
    exp_q.push_back(32'hC);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (IF_ID_valid !== 1'b1 || IF_ID_PC !== e) begin
      errors++;
      $display("FAIL lu_after got v=%b pc=%h want v=1 pc=%h",
               IF_ID_valid, IF_ID_PC, e);
    end
  endtask

  task automatic test_wait_states;
    logic [31:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      exp_q.push_back(32'(i * 4));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (IF_ID_valid !== 1'b1 || IF_ID_PC !== e) begin
        errors++;
        $display("FAIL ws_pre got v=%b pc=%h want v=1 pc=%h",
                 IF_ID_valid, IF_ID_PC, e);
      end
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
        errors++;
        $display("FAIL ws_addr got req=%b addr=%h want req=1 addr=10",
                 imem_req, imem_addr);
      end
      tick();
      checks++;
      if (IF_ID_valid !== 1'b0 || IF_ID_instr !== NOP) begin
        errors++;
        $display("FAIL ws_bubble got v=%b i=%h want v=0 i=%h",
                 IF_ID_valid, IF_ID_instr, NOP);
      end
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    exp_q.push_back(32'h10);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (IF_ID_valid !== 1'b1 || IF_ID_PC !== e ||
        IF_ID_instr !== memw(e)) begin
      errors++;
      $display("FAIL ws_arrive got v=%b pc=%h i=%h want pc=%h i=%h",
               IF_ID_valid, IF_ID_PC, IF_ID_instr, e, memw(e));
    end
  endtask

  task automatic test_redirect_pending;
    logic [31:0] e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      exp_q.push_back(32'(i * 4));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (IF_ID_valid !== 1'b1 || IF_ID_PC !== e) begin
        errors++;
        $display("FAIL rp_pre got v=%b pc=%h want v=1 pc=%h",
                 IF_ID_valid, IF_ID_PC, e);
      end
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h100);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h20 ||
          IF_ID_valid !== 1'b0) begin
        errors++;
        $display("FAIL rp_drain got req=%b addr=%h v=%b want 1 20 0",
                 imem_req, imem_addr, IF_ID_valid);
      end
      tick();
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (imem_addr !== 32'h20) begin
      errors++;
      $display("FAIL rp_held got addr=%h want 20", imem_addr);
    end
    tick();
    checks++;
    if (IF_ID_valid !== 1'b0 || imem_req !== 1'b1 ||
        imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL rp_target got v=%b req=%b addr=%h want 0 1 100",
               IF_ID_valid, imem_req, imem_addr);
    end
    exp_q.push_back(32'h100);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (IF_ID_valid !== 1'b1 || IF_ID_PC !== e ||
        IF_ID_instr !== memw(e)) begin
      errors++;
      $display("FAIL rp_arrive got v=%b pc=%h i=%h want pc=%h i=%h",
               IF_ID_valid, IF_ID_PC, IF_ID_instr, e, memw(e));
    end
  endtask

  task automatic test_redirect_in_drain;
    logic [31:0] e;
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h100);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h206);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rd_hold got req=%b addr=%h want req=1 addr=0",
               imem_req, imem_addr);
    end
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (imem_addr !== 32'h0 || IF_ID_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_still got addr=%h v=%b want addr=0 v=0",
               imem_addr, IF_ID_valid);
    end
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h204 ||
        IF_ID_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_newest got req=%b addr=%h v=%b want 1 204 0",
               imem_req, imem_addr, IF_ID_valid);
    end
    exp_q.push_back(32'h204);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (IF_ID_valid !== 1'b1 || IF_ID_PC !== e) begin
      errors++;
      $display("FAIL rd_arrive got v=%b pc=%h want v=1 pc=%h",
               IF_ID_valid, IF_ID_PC, e);
    end
  endtask

  task automatic test_redirect_stall;
    logic [31:0] e;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      exp_q.push_back(32'(i * 4));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (IF_ID_valid !== 1'b1 || IF_ID_PC !== e) begin
        errors++;
        $display("FAIL rs_pre got v=%b pc=%h want v=1 pc=%h",
                 IF_ID_valid, IF_ID_PC, e);
      end
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h40);
    tick();
    checks++;
    if (IF_ID_valid !== 1'b0 || IF_ID_instr !== NOP) begin
      errors++;
      $display("FAIL rs_flush got v=%b i=%h want v=0 i=%h",
               IF_ID_valid, IF_ID_instr, NOP);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      errors++;
      $display("FAIL rs_target got req=%b addr=%h want req=1 addr=40",
               imem_req, imem_addr);
    end
    exp_q.push_back(32'h40);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (IF_ID_valid !== 1'b1 || IF_ID_PC !== e ||
        IF_ID_instr !== memw(e)) begin
      errors++;
      $display("FAIL rs_arrive got v=%b pc=%h i=%h want pc=%h i=%h",
               IF_ID_valid, IF_ID_PC, IF_ID_instr, e, memw(e));
    end
  endtask

  task automatic test_reset_mid_drain;
    logic [31:0] e;
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h80);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL rm_drain got req=%b addr=%h want req=1 addr=4",
               imem_req, imem_addr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL rm_reqlow got req=%b want 0", imem_req);
    end
    tick();
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 ||
        IF_ID_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_reset got req=%b addr=%h v=%b want 0 0 0",
               imem_req, imem_addr, IF_ID_valid);
    end
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rm_restart got req=%b addr=%h want req=1 addr=0",
               imem_req, imem_addr);
    end
    exp_q.push_back(32'h0);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (IF_ID_valid !== 1'b1 || IF_ID_PC !== e ||
        IF_ID_instr !== memw(e)) begin
      errors++;
      $display("FAIL rm_arrive got v=%b pc=%h i=%h want pc=%h i=%h",
               IF_ID_valid, IF_ID_PC, IF_ID_instr, e, memw(e));
    end
  endtask

  task automatic test_wrap;
    logic [31:0] e;
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC || IF_ID_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_target got addr=%h v=%b want fffffffc 0",
               imem_addr, IF_ID_valid);
    end
    exp_q.push_back(32'hFFFF_FFFC);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (IF_ID_valid !== 1'b1 || IF_ID_PC !== e ||
        imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL wr_wrap got v=%b pc=%h addr=%h want 1 %h 0",
               IF_ID_valid, IF_ID_PC, imem_addr, e);
    end
  endtask

  initial begin
    reset      = 1'b1;
    PC_E       = 1'b1;
    IF_ID_E    = 1'b1;
    redirect   = 1'b0;
    TA         = 32'h0;
    imem_ready = 1'b1;
    test_reset();
    test_sequential();
    test_load_use();
    test_wait_states();
    test_redirect_pending();
    test_redirect_in_drain();
    test_redirect_stall();
    test_reset_mid_drain();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
